bcd_digit_feeder: RTL

// - Sequential binary-to-BCD converter (shift-and-add-3 / double-dabble), one bit per clock.
// - Upstream feeder for a bank of seven-segment decoder stages.
// - Drives one 4-bit BCD digit per decoder and a one-cycle displayWrite strobe shared by all.
// - Decoders sit directly downstream; display updates only when a conversion completes.

---
 rtl/bcd_pkg.sv | 37 +++
 rtl/bcd_add3.sv | 14 +
 rtl/bcd_digit_feeder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD digit feeder.
//   BCD_W          width of one BCD digit
//   feeder_state_t controller states
//   bcd_digits()   decimal digits needed to hold any unsigned value of a given bit width
//   pow10()        10**n, saturating at the 64-bit maximum
package bcd_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WRITE = 2'd2
  } feeder_state_t;

  // ceil(width*log10(2)) using a fixed-point log10(2) = 0.30103.
  // width*log10(2) is never an integer for width >= 1, so the rounding is exact.
  function automatic int bcd_digits(input int width);
    longint num;
    num = longint'(width) * 64'sd30103 + 64'sd99999;
    return int'(num / 64'sd100000);
  endfunction

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      if (p > 64'd1844674407370955161) begin
        p = 64'hFFFF_FFFF_FFFF_FFFF;
      end else begin
        p = p * 64'd10;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: digits of 5 or more get 3 added so that the
// following left shift carries correctly into the next decimal digit.
//   i_nib  accumulator digit before the shift
//   o_nib  corrected digit
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] i_nib,
  output logic [BCD_W-1:0] o_nib
);

  assign o_nib = (i_nib >= 4'd5) ? (i_nib + 4'd3) : i_nib;

endmodule

// File: rtl/bcd_digit_feeder.sv
// Sequential binary-to-BCD converter feeding a bank of seven-segment decoders.
// One input bit is consumed per clock; the result is written to the digit
// registers with a single-cycle displayWrite strobe when the conversion ends.
//   clk           system clock, rising edge
//   reset         asynchronous active-high reset
//   binIn         unsigned value, sampled when start is accepted
//   start         conversion request, honoured only in IDLE
//   busy          conversion in progress, through the strobe cycle
//   done          one-cycle completion pulse, same cycle as displayWrite
//   overflow      last value did not fit in DIGITS decimal digits
//   digits        BCD result, digit k = digits[4k+3:4k]
//   displayWrite  write enable for the downstream decoders
//
// state | meaning
// IDLE  | waiting for start, outputs held
// SHIFT | one add-3/shift step per cycle, DATA_W cycles
// WRITE | publish result, pulse displayWrite/done
module bcd_digit_feeder
  import bcd_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_W-1:0]       binIn,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [BCD_W*DIGITS-1:0] digits,
  output logic                    displayWrite
);

  localparam int ACC_D = bcd_digits(DATA_W);
  localparam int ACC_W = BCD_W * ACC_D;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  feeder_state_t             r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic [DATA_W-1:0]         r_shift;
  logic [ACC_W-1:0]          r_acc;
  logic [BCD_W*DIGITS-1:0]   r_digits;
  logic                      r_ovf;
  logic                      r_busy;
  logic                      r_done;
  logic                      r_dw;

  logic [ACC_W-1:0]          w_adj;
  logic                      w_ovf;
  logic [BCD_W*DIGITS-1:0]   w_digits;

  for (genvar g = 0; g < ACC_D; g++) begin : g_add3
    bcd_add3 u_add3 (
      .i_nib(r_acc[g*BCD_W +: BCD_W]),
      .o_nib(w_adj[g*BCD_W +: BCD_W])
    );
  end

  // Any nonzero digit above the displayed ones means value > 10^DIGITS-1.
  if (ACC_D > DIGITS) begin : g_ovf
    assign w_ovf = |r_acc[ACC_W-1:BCD_W*DIGITS];
  end else begin : g_no_ovf
    assign w_ovf = 1'b0;
  end

  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    if (k < ACC_D) begin : g_acc
      assign w_digits[k*BCD_W +: BCD_W] = w_ovf ? 4'd9 : r_acc[k*BCD_W +: BCD_W];
    end else begin : g_pad
      assign w_digits[k*BCD_W +: BCD_W] = 4'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_shift  <= '0;
      r_acc    <= '0;
      r_digits <= '0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_dw     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dw   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_shift <= binIn;
            r_acc   <= '0;
            r_cnt   <= CNT_W'(DATA_W - 1);
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end else begin
            // busy stays up through the strobe cycle and drops here
            r_busy <= 1'b0;
          end
        end
        SHIFT: begin
          r_acc   <= {w_adj[ACC_W-2:0], r_shift[DATA_W-1]};
          r_shift <= r_shift << 1;
          if (r_cnt == '0) begin
            r_state <= WRITE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        WRITE: begin
          r_digits <= w_digits;
          r_ovf    <= w_ovf;
          r_dw     <= 1'b1;
          r_done   <= 1'b1;
          r_state  <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign overflow     = r_ovf;
  assign digits       = r_digits;
  assign displayWrite = r_dw;

endmodule
